// File: rtl/sparse_pe_sched.sv
// Sequencer for sparse_pe over a stream of 2:4-compressed blocks, accumulating one sum per vector.
// Optional mask validation is compiled in with `define SPARSE_PE_SCHED_MASK_CHECK_EN.
module sparse_pe_sched #(
  parameter int unsigned PE_LAT = 1,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_act,
  input  logic [3:0]       in_mask,
  input  logic [31:0]      in_wgrp,
  input  logic             in_last,
  output logic [15:0]      pe_act,
  output logic [3:0]       pe_mask,
  output logic [7:0]       pe_w_top,
  output logic [7:0]       pe_w_bot,
  input  logic [31:0]      pe_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_blocks,
  output logic             out_err
);

  localparam int unsigned LatW = $clog2(PE_LAT + 2);

  typedef enum logic [1:0] {StIdle, StDrive, StAccum, StDone} state_e;

  state_e            state_q, state_d;
  logic [15:0]       act_q;
  logic [3:0]        mask_q;
  logic [31:0]       wgrp_q;
  logic              last_q;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic              err_q, err_d;
  logic              in_ready_q;

  logic              hs;
  logic [1:0]        top_idx, bot_idx;
  logic [2:0]        pop;
  logic              blk_bad;
  logic [ACC_W-1:0]  pe_ext;

  // in_ready_q is only ever high in StIdle
  assign hs = in_valid && in_ready_q;

  // Highest set bit selects the top weight, next-highest the bottom one.
  always_comb begin
    top_idx = '0;
    bot_idx = '0;
    pop     = '0;
    for (int k = 3; k >= 0; k--) begin
      if (mask_q[k]) begin
        if (pop == 3'd0) begin
          top_idx = 2'(k);
        end else if (pop == 3'd1) begin
          bot_idx = 2'(k);
        end
        pop = pop + 3'd1;
      end
    end
  end

`ifdef SPARSE_PE_SCHED_MASK_CHECK_EN
  assign blk_bad = (pop != 3'd2);
`else
  assign blk_bad = 1'b0;
`endif

  assign pe_ext = ACC_W'(signed'(pe_result));

  always_comb begin
    pe_act   = '0;
    pe_mask  = '0;
    pe_w_top = '0;
    pe_w_bot = '0;
    if (state_q == StDrive) begin
      if (blk_bad) begin
        pe_mask = 4'b0011;
      end else begin
        pe_act   = act_q;
        pe_mask  = mask_q;
        pe_w_top = wgrp_q[{top_idx, 3'b000} +: 8];
        pe_w_bot = wgrp_q[{bot_idx, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    acc_d     = acc_q;
    blk_cnt_d = blk_cnt_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          state_d   = StDrive;
          lat_cnt_d = '0;
        end
      end
      StDrive: begin
        if (lat_cnt_q == LatW'(PE_LAT)) begin
          state_d = StAccum;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      StAccum: begin
        acc_d     = acc_q + (blk_bad ? '0 : pe_ext);
        blk_cnt_d = blk_cnt_q + 1'b1;
        err_d     = err_q | blk_bad;
        state_d   = last_q ? StDone : StIdle;
      end
      StDone: begin
        if (out_ready) begin
          acc_d     = '0;
          blk_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      lat_cnt_q  <= '0;
      acc_q      <= '0;
      blk_cnt_q  <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      act_q      <= '0;
      mask_q     <= '0;
      wgrp_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      acc_q      <= acc_d;
      blk_cnt_q  <= blk_cnt_d;
      err_q      <= err_d;
      in_ready_q <= (state_d == StIdle);
      if (hs) begin
        act_q  <= in_act;
        mask_q <= in_mask;
        wgrp_q <= in_wgrp;
        last_q <= in_last;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q == StDone);
  assign out_sum    = acc_q;
  assign out_blocks = blk_cnt_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_sparse_pe_sched.sv
// Scoreboard bench for sparse_pe_sched with a behavioural PE_LAT=1 sparse_pe stand-in.
module tb_sparse_pe_sched;

  localparam int unsigned PE_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_act = '0;
  logic [3:0]  in_mask = '0;
  logic [31:0] in_wgrp = '0;
  logic        in_last = 1'b0;
  logic [15:0] pe_act;
  logic [3:0]  pe_mask;
  logic [7:0]  pe_w_top;
  logic [7:0]  pe_w_bot;
  logic [31:0] pe_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic [15:0] out_blocks;
  logic        out_err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic [15:0] blocks;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] m_acc = '0;
  logic [15:0] m_blk = '0;
  logic        m_err = 1'b0;

  logic        force_en = 1'b0;
  logic [31:0] force_val = '0;

  always #5 clk = ~clk;

  sparse_pe_sched #(.PE_LAT(PE_LAT), .ACC_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_act     (in_act),
    .in_mask    (in_mask),
    .in_wgrp    (in_wgrp),
    .in_last    (in_last),
    .pe_act     (pe_act),
    .pe_mask    (pe_mask),
    .pe_w_top   (pe_w_top),
    .pe_w_bot   (pe_w_bot),
    .pe_result  (pe_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_blocks (out_blocks),
    .out_err    (out_err)
  );

  function automatic logic [31:0] pe_prod(input logic [15:0] a, input logic [7:0] wt,
                                          input logic [7:0] wb);
    logic signed [7:0] at, ab, st, sw;
    int r;
    at = a[15:8];
    ab = a[7:0];
    st = wt;
    sw = wb;
    r  = int'(at) * int'(st) + int'(ab) * int'(sw);
    return r;
  endfunction

  // One-cycle PE; force_* lets the bench inject results beyond the 8x8 product range.
  always @(posedge clk) begin
    if (force_en) pe_result <= force_val;
    else          pe_result <= pe_prod(pe_act, pe_w_top, pe_w_bot);
  end

  function automatic int popcnt4(input logic [3:0] m);
    return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
  endfunction

  function automatic logic [31:0] block_val(input logic [15:0] a, input logic [3:0] m,
                                            input logic [31:0] w);
    int n;
    int ti;
    int bi;
    logic [7:0] wt;
    logic [7:0] wb;
    n  = 0;
    ti = 0;
    bi = 0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) begin
        if (n == 0) ti = k;
        else if (n == 1) bi = k;
        n++;
      end
    end
`ifdef SPARSE_PE_SCHED_MASK_CHECK_EN
    if (n != 2) return 32'd0;
`endif
    wt = w[8*ti +: 8];
    wb = w[8*bi +: 8];
    return pe_prod(a, wt, wb);
  endfunction

  task automatic send_block(input logic [15:0] a, input logic [3:0] m, input logic [31:0] w,
                            input logic l, input logic fe, input logic [31:0] fv);
    bit ok;
    bit bad;
    ok       = 1'b0;
    in_act   = a;
    in_mask  = m;
    in_wgrp  = w;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok        = 1'b1;
        force_en  = fe;
        force_val = fv;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL handshake_timeout got in_ready=0 want in_ready=1 within 50 cycles");
    else n_pass++;
    if (ok) begin
`ifdef SPARSE_PE_SCHED_MASK_CHECK_EN
      bad = (popcnt4(m) != 2);
`else
      bad = 1'b0;
`endif
      m_acc = m_acc + (fe ? fv : block_val(a, m, w));
      m_blk = m_blk + 16'd1;
      m_err = m_err | bad;
      if (l) begin
        sb.push_back('{sum: m_acc, blocks: m_blk, err: m_err});
        m_acc = '0;
        m_blk = '0;
        m_err = 1'b0;
      end
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!out_valid) $display("FAIL out_valid_timeout got 0 want 1 within 100 cycles");
    else n_pass++;
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else n_pass++;
    n_checks++;
    if ({out_valid, out_err, out_sum, out_blocks} !== '0)
      $display("FAIL rst_outputs got %h want 0", {out_valid, out_err, out_sum, out_blocks});
    else n_pass++;
    n_checks++;
    if ({pe_act, pe_mask, pe_w_top, pe_w_bot} !== '0)
      $display("FAIL rst_pe got %h want 0", {pe_act, pe_mask, pe_w_top, pe_w_bot});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_single();
    int cyc;
    send_block(16'h0302, 4'b0101, 32'h0A0B0C0D, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (pe_w_top !== 8'h0B) $display("FAIL single_w_top got %h want 0b", pe_w_top); else n_pass++;
    n_checks++;
    if (pe_w_bot !== 8'h0D) $display("FAIL single_w_bot got %h want 0d", pe_w_bot); else n_pass++;
    n_checks++;
    if ({pe_act, pe_mask} !== {16'h0302, 4'b0101})
      $display("FAIL single_act_mask got %h want 03025", {pe_act, pe_mask});
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL single_ready_drop got %b want 0", in_ready); else n_pass++;
    wait_valid(cyc);
    n_checks++;
    if (cyc != PE_LAT + 3) $display("FAIL single_latency got %0d want %0d", cyc, PE_LAT + 3);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (out_sum !== e.sum) $display("FAIL single_sum got %0d want %0d", out_sum, e.sum); else n_pass++;
    n_checks++;
    if (out_blocks !== e.blocks) $display("FAIL single_blocks got %0d want %0d", out_blocks, e.blocks);
    else n_pass++;
    n_checks++;
    if (out_err !== e.err) $display("FAIL single_err got %b want %b", out_err, e.err); else n_pass++;
    accept_out();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL single_release got valid,ready=%b want 01", {out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_multi();
    int cyc;
    for (int b = 0; b < 3; b++) begin
      send_block(16'h0101, 4'b1100, 32'h02030000, (b == 2), 1'b0, 32'h0);
      n_checks++;
      if ({pe_w_top, pe_w_bot} !== 16'h0203)
        $display("FAIL multi_weights blk%0d got %h want 0203", b, {pe_w_top, pe_w_bot});
      else n_pass++;
    end
    wait_valid(cyc);
    e = sb.pop_front();
    n_checks++;
    if (out_sum !== e.sum) $display("FAIL multi_sum got %0d want %0d", out_sum, e.sum); else n_pass++;
    n_checks++;
    if (out_blocks !== e.blocks) $display("FAIL multi_blocks got %0d want %0d", out_blocks, e.blocks);
    else n_pass++;
    accept_out();
  endtask

  task automatic test_invalid_mask();
    int cyc;
    logic [23:0] exp_pe;
`ifdef SPARSE_PE_SCHED_MASK_CHECK_EN
    exp_pe = {16'h0000, 4'b0011, 4'b0000};
`else
    exp_pe = {16'h0505, 4'b0111, 4'b0000};
`endif
    send_block(16'h0101, 4'b1100, 32'h02030000, 1'b0, 1'b0, 32'h0);
    send_block(16'h0505, 4'b0111, 32'h01010101, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({pe_act, pe_mask, 4'b0000} !== exp_pe)
      $display("FAIL invalid_pe_drive got %h want %h", {pe_act, pe_mask, 4'b0000}, exp_pe);
    else n_pass++;
    send_block(16'h0101, 4'b1100, 32'h02030000, 1'b1, 1'b0, 32'h0);
    wait_valid(cyc);
    e = sb.pop_front();
    n_checks++;
    if (out_sum !== e.sum) $display("FAIL invalid_sum got %0d want %0d", out_sum, e.sum); else n_pass++;
    n_checks++;
    if (out_blocks !== e.blocks) $display("FAIL invalid_blocks got %0d want %0d", out_blocks, e.blocks);
    else n_pass++;
    n_checks++;
    if (out_err !== e.err) $display("FAIL invalid_err got %b want %b", out_err, e.err); else n_pass++;
    accept_out();
    // Sticky error must clear once the vector is consumed.
    n_checks++;
    if (out_err !== 1'b0) $display("FAIL invalid_err_clear got %b want 0", out_err); else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc;
    send_block(16'h0402, 4'b1010, 32'h05000600, 1'b1, 1'b0, 32'h0);
    wait_valid(cyc);
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({out_valid, in_ready} !== 2'b10)
        $display("FAIL bp_hold cyc%0d got valid,ready=%b want 10", i, {out_valid, in_ready});
      else n_pass++;
      n_checks++;
      if (out_sum !== e.sum) $display("FAIL bp_sum cyc%0d got %0d want %0d", i, out_sum, e.sum);
      else n_pass++;
      @(negedge clk);
    end
    accept_out();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL bp_release got valid,ready=%b want 01", {out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int cyc;
    send_block(16'h0101, 4'b1100, 32'h02030000, 1'b0, 1'b0, 32'h0);
    send_block(16'h0202, 4'b0011, 32'h00000403, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({pe_act, pe_mask, pe_w_top, pe_w_bot} !== '0)
      $display("FAIL abort_pe got %h want 0", {pe_act, pe_mask, pe_w_top, pe_w_bot});
    else n_pass++;
    n_checks++;
    if ({out_valid, out_err, out_sum, out_blocks, in_ready} !== '0)
      $display("FAIL abort_outputs got %h want 0", {out_valid, out_err, out_sum, out_blocks, in_ready});
    else n_pass++;
    m_acc = '0;
    m_blk = '0;
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_block(16'h0302, 4'b0101, 32'h0A0B0C0D, 1'b1, 1'b0, 32'h0);
    wait_valid(cyc);
    e = sb.pop_front();
    n_checks++;
    if (out_sum !== e.sum) $display("FAIL abort_new_sum got %0d want %0d", out_sum, e.sum); else n_pass++;
    n_checks++;
    if (out_blocks !== e.blocks) $display("FAIL abort_new_blocks got %0d want %0d", out_blocks, e.blocks);
    else n_pass++;
    accept_out();
  endtask

  task automatic test_signed_wrap();
    int cyc;
    send_block(16'hFF01, 4'b0011, 32'h00007F01, 1'b1, 1'b0, 32'h0);
    wait_valid(cyc);
    e = sb.pop_front();
    n_checks++;
    if (out_sum !== e.sum) $display("FAIL signed_sum got %h want %h", out_sum, e.sum); else n_pass++;
    accept_out();
    send_block(16'h0101, 4'b0011, 32'h00000101, 1'b0, 1'b1, 32'h7FFFFFFF);
    send_block(16'h0101, 4'b0011, 32'h00000101, 1'b1, 1'b1, 32'h00000001);
    wait_valid(cyc);
    e = sb.pop_front();
    n_checks++;
    if (out_sum !== e.sum) $display("FAIL wrap_sum got %h want %h", out_sum, e.sum); else n_pass++;
    n_checks++;
    if (out_blocks !== e.blocks) $display("FAIL wrap_blocks got %0d want %0d", out_blocks, e.blocks);
    else n_pass++;
    accept_out();
    force_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish before 2ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_invalid_mask();
    test_backpressure();
    test_reset_abort();
    test_signed_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
